thermometer_decoder: RTL and testbench



---
 rtl/thermometer_decoder_pkg.sv | 19 +
 rtl/thermometer_decoder_if.sv | 29 ++
 rtl/thermometer_decoder_code_check.sv | 31 +++
 rtl/thermometer_decoder.sv | 104 ++++++++++
 tb/tb_thermometer_decoder.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/thermometer_decoder_pkg.sv
// Shared definitions for thermometer-code consumers.
//   DEF_WIDTH   : default thermometer code width
//   level_w()   : width of a binary level able to hold 0..w
//   dec_state_e : decoder FSM states
package thermometer_pkg;

    localparam int DEF_WIDTH = 16;

    function automatic int level_w(input int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic [1:0] {
        ST_WAIT     = 2'd0,   // nothing committed since reset
        ST_LOCKED   = 2'd1,   // sampled level matches level_out
        ST_SETTLING = 2'd2    // legal level differs from level_out, counting
    } dec_state_e;

endpackage

// File: rtl/thermometer_decoder_if.sv
// Bus between a thermometer-code source and the decoder.
//   master : drives therm_in/peak_clr, observes the decoded outputs
//   slave  : the decoder side
interface thermometer_decoder_if
    import thermometer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CW = level_w(WIDTH);

    logic [WIDTH-1:0] therm_in;
    logic             peak_clr;
    logic [CW-1:0]    level_out;
    logic             level_valid;
    logic             changed;
    logic             bubble_err;
    logic [CW-1:0]    peak_out;

    modport master (
        output therm_in, peak_clr,
        input  level_out, level_valid, changed, bubble_err, peak_out
    );

    modport slave (
        input  therm_in, peak_clr,
        output level_out, level_valid, changed, bubble_err, peak_out
    );

endinterface

// File: rtl/thermometer_decoder_code_check.sv
// Combinational thermometer-code checker.
//   code_i  : thermometer code, bit 0 = lowest segment
//   cand_o  : number of contiguous ones starting at bit 0
//   legal_o : high when no one appears above the first zero
module therm_code_check #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic [WIDTH-1:0] code_i,
    output logic [CW-1:0]    cand_o,
    output logic             legal_o
);

    logic zero_seen;

    always_comb begin
        cand_o    = '0;
        legal_o   = 1'b1;
        zero_seen = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (code_i[i]) begin
                // a one above a gap is a bubble
                if (zero_seen) legal_o = 1'b0;
                else           cand_o  = CW'(i + 1);
            end else begin
                zero_seen = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thermometer_decoder.sv
// Thermometer-code decoder with bubble rejection, debounce and peak hold.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : therm_in/peak_clr in; level_out, level_valid, changed,
//                  bubble_err, peak_out out
// A level is committed once STABLE_CYCLES consecutive identical legal samples
// have been seen; changed pulses for one cycle on every commit.
module thermometer_decoder
    import thermometer_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    thermometer_decoder_if.slave  bus
);

    localparam int            CW      = level_w(WIDTH);
    localparam int            RW      = 4;
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);

    logic [WIDTH-1:0] sample_q;
    logic [CW-1:0]    prev_cand_q;
    logic [RW-1:0]    run_q, run_d;
    dec_state_e       state_q, state_d;
    logic [CW-1:0]    level_q, level_d;
    logic             valid_q;
    logic             changed_q;
    logic             bubble_q;
    logic [CW-1:0]    peak_q, peak_d;

    logic [CW-1:0]    cand;
    logic             legal;
    logic             commit;

    therm_code_check #(.WIDTH(WIDTH), .CW(CW)) u_check (
        .code_i  (sample_q),
        .cand_o  (cand),
        .legal_o (legal)
    );

    always_comb begin
        run_d = run_q;
        if (!legal)                  run_d = '0;
        else if (cand != prev_cand_q) run_d = RW'(1);
        else if (run_q != RUN_MAX)   run_d = run_q + RW'(1);
    end

    // In WAIT the first stable level commits even if it equals the reset
    // value of level_out; afterwards only a differing level commits.
    assign commit = legal && (run_d == RUN_MAX) &&
                    ((state_q == ST_WAIT) || (cand != level_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:     if (commit) state_d = ST_LOCKED;
            ST_LOCKED:   if (legal && (cand != level_q) && !commit) state_d = ST_SETTLING;
            ST_SETTLING: if (commit || (legal && (cand == level_q))) state_d = ST_LOCKED;
            default:     state_d = ST_WAIT;
        endcase
    end

    assign level_d = commit ? cand : level_q;

    // peak_clr reloads from level_d so a coincident commit wins, and WAIT
    // yields 0 because level_q is still at its reset value.
    always_comb begin
        peak_d = peak_q;
        if (bus.peak_clr)                 peak_d = level_d;
        else if (commit && (cand > peak_q)) peak_d = cand;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q    <= '0;
            prev_cand_q <= '0;
            run_q       <= '0;
            state_q     <= ST_WAIT;
            level_q     <= '0;
            valid_q     <= 1'b0;
            changed_q   <= 1'b0;
            bubble_q    <= 1'b0;
            peak_q      <= '0;
        end else begin
            sample_q    <= bus.therm_in;
            prev_cand_q <= cand;
            run_q       <= run_d;
            state_q     <= state_d;
            level_q     <= level_d;
            valid_q     <= valid_q | commit;
            changed_q   <= commit;
            bubble_q    <= !legal;
            peak_q      <= peak_d;
        end
    end

    assign bus.level_out   = level_q;
    assign bus.level_valid = valid_q;
    assign bus.changed     = changed_q;
    assign bus.bubble_err  = bubble_q;
    assign bus.peak_out    = peak_q;

endmodule

// File: tb/tb_thermometer_decoder.sv
// Directed self-checking bench for thermometer_decoder (WIDTH 16, 4 cycles).
module tb_thermometer_decoder;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;
    int   pulses;

    thermometer_decoder_if #(.WIDTH(16)) bus ();

    thermometer_decoder #(.WIDTH(16), .STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // advance n edges, settle 1 time unit past the last one; counts changed pulses
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.changed) pulses++;
        end
    endtask

    task automatic chk_out(input string tag, input int lvl, input int vld, input int chg, input int pk);
        chk({tag, ".level"},   32'(bus.level_out),   32'(lvl));
        chk({tag, ".valid"},   32'(bus.level_valid), 32'(vld));
        chk({tag, ".changed"}, 32'(bus.changed),     32'(chg));
        chk({tag, ".peak"},    32'(bus.peak_out),    32'(pk));
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        pulses       = 0;
        reset_n      = 1'b0;
        bus.therm_in = 16'h0000;
        bus.peak_clr = 1'b0;

        // reset state
        step(2);
        chk_out("rst", 0, 0, 0, 0);
        chk("rst.bubble", 32'(bus.bubble_err), 0);

        // first commit: capture edge + 4
        reset_n      = 1'b1;
        bus.therm_in = 16'h00FF;
        step(4);
        chk_out("lvl8_pre", 0, 0, 0, 0);
        step(1);
        chk_out("lvl8", 8, 1, 1, 8);
        step(1);
        chk("lvl8.pulse_end", 32'(bus.changed), 0);

        // short excursion never commits
        pulses       = 0;
        bus.therm_in = 16'h0FFF;
        step(3);
        bus.therm_in = 16'h00FF;
        step(8);
        chk("glitch.pulses", 32'(pulses), 0);
        chk("glitch.level", 32'(bus.level_out), 8);

        // bubble code
        pulses       = 0;
        bus.therm_in = 16'h00F7;
        step(1);
        chk("bub.lag", 32'(bus.bubble_err), 0);
        step(1);
        chk("bub.err", 32'(bus.bubble_err), 1);
        step(8);
        chk("bub.err_hold", 32'(bus.bubble_err), 1);
        chk("bub.level", 32'(bus.level_out), 8);
        chk("bub.pulses", 32'(pulses), 0);

        bus.therm_in = 16'h0007;
        step(4);
        chk("lvl3_pre.level", 32'(bus.level_out), 8);
        chk("lvl3_pre.bubble", 32'(bus.bubble_err), 0);
        step(1);
        chk_out("lvl3", 3, 1, 1, 8);

        // full scale, then empty
        bus.therm_in = 16'hFFFF;
        step(5);
        chk_out("lvl16", 16, 1, 1, 16);
        bus.therm_in = 16'h0000;
        step(5);
        chk_out("lvl0", 0, 1, 1, 16);

        // peak_clr coinciding with commit to 5
        bus.therm_in = 16'h001F;
        step(4);
        bus.peak_clr = 1'b1;
        step(1);
        bus.peak_clr = 1'b0;
        chk_out("lvl5_clr", 5, 1, 1, 5);

        // plain peak_clr reloads current level
        bus.therm_in = 16'h0000;
        step(5);
        chk_out("lvl0b", 0, 1, 1, 5);
        bus.peak_clr = 1'b1;
        step(1);
        bus.peak_clr = 1'b0;
        chk("clr.peak", 32'(bus.peak_out), 0);
        chk("clr.changed", 32'(bus.changed), 0);

        // reset during SETTLING toward 12
        bus.therm_in = 16'h0FFF;
        step(2);
        reset_n = 1'b0;
        #1;
        chk_out("midrst", 0, 0, 0, 0);
        chk("midrst.bubble", 32'(bus.bubble_err), 0);
        step(1);
        reset_n = 1'b1;
        step(4);
        chk_out("post_rst_pre", 0, 0, 0, 0);
        step(1);
        chk_out("post_rst", 12, 1, 1, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
